// File: rtl/mem_data_ctrl_if.sv
// Bundle of the pipeline-side memory request signals and the SRAM port
// driven by mem_data_ctrl.
interface mem_data_ctrl_if;
  logic [1:0]  MEM_in;
  logic [12:0] Address_in;
  logic [1:0]  Size_in;
  logic        Unsigned_in;
  logic [31:0] Write_data_in;
  logic [31:0] Read_data_out;
  logic        stall;
  logic        misalign;
  logic        sram_cs;
  logic [3:0]  sram_we;
  logic [10:0] sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout;

  modport master (
    output MEM_in, Address_in, Size_in, Unsigned_in, Write_data_in, sram_dout,
    input  Read_data_out, stall, misalign, sram_cs, sram_we, sram_addr, sram_din
  );

  modport slave (
    input  MEM_in, Address_in, Size_in, Unsigned_in, Write_data_in, sram_dout,
    output Read_data_out, stall, misalign, sram_cs, sram_we, sram_addr, sram_din
  );
endinterface

// File: rtl/mem_data_ctrl.sv
// MEM-stage data memory controller: turns one load/store request into a single
// SRAM access with a fixed number of wait states, stalling the pipeline meanwhile.
module mem_data_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  mem_data_ctrl_if.slave  bus
);

  localparam int DATA_W = 32;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

  logic [1:0]        state;
  logic [2:0]        wait_cnt;

  logic              req_load;
  logic [1:0]        req_lane;
  logic [1:0]        req_size;
  logic              req_uns;

  logic              sram_cs_q;
  logic [3:0]        sram_we_q;
  logic [10:0]       sram_addr_q;
  logic [DATA_W-1:0] sram_din_q;
  logic [DATA_W-1:0] rd_data_q;

  logic              req_any;
  logic              req_is_load;
  logic              req_misal;
  logic              start;

  function automatic logic [3:0] store_lanes(input logic [1:0] size,
                                             input logic [1:0] lane);
    logic [3:0] we;
    case (size)
      2'b00:   we = 4'b0001 << lane;
      2'b01:   we = 4'b0011 << lane;
      default: we = 4'b1111;
    endcase
    return we;
  endfunction

  function automatic logic [DATA_W-1:0] store_data(input logic [1:0]        size,
                                                   input logic [DATA_W-1:0] wd);
    logic [DATA_W-1:0] d;
    case (size)
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // Pick the addressed lane and sign/zero-extend it to the full word.
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                    input logic [1:0]        lane,
                                                    input logic [1:0]        size,
                                                    input logic              uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [DATA_W-1:0]  r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = {{24{~uns & b[7]}}, b};
      2'b01:   r = {{16{~uns & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // IDLE-stage request decode: read wins when both strobes are high
  always_comb begin
    req_any     = |bus.MEM_in;
    req_is_load = bus.MEM_in[1];
    req_misal   = 1'b0;
    case (bus.Size_in)
      2'b00:   req_misal = 1'b0;
      2'b01:   req_misal = bus.Address_in[0];
      default: req_misal = |bus.Address_in[1:0];
    endcase
    start = !rst && (state == IDLE) && req_any && !req_misal;
  end

  assign bus.stall         = !rst && (start || state == ACCESS || state == WAIT);
  assign bus.misalign      = !rst && (state == IDLE) && req_any && req_misal;
  assign bus.sram_cs       = sram_cs_q;
  assign bus.sram_we       = sram_we_q;
  assign bus.sram_addr     = sram_addr_q;
  assign bus.sram_din      = sram_din_q;
  assign bus.Read_data_out = rd_data_q;

  // Request latch: fields are only sampled on the IDLE->ACCESS edge
  always_ff @(posedge clk) begin
    if (start) begin
      req_load <= req_is_load;
      req_lane <= bus.Address_in[1:0];
      req_size <= bus.Size_in;
      req_uns  <= bus.Unsigned_in;
    end
  end

  // Access sequencing and SRAM port registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= 3'd0;
      sram_cs_q   <= 1'b0;
      sram_we_q   <= 4'b0000;
      sram_addr_q <= 11'd0;
      sram_din_q  <= '0;
      rd_data_q   <= '0;
    end else begin
      sram_cs_q <= 1'b0;
      sram_we_q <= 4'b0000;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= ACCESS;
            sram_cs_q   <= 1'b1;
            sram_addr_q <= bus.Address_in[12:2];
            sram_we_q   <= req_is_load ? 4'b0000
                                       : store_lanes(bus.Size_in, bus.Address_in[1:0]);
            sram_din_q  <= store_data(bus.Size_in, bus.Write_data_in);
          end
        end
        ACCESS: begin
          if (WAIT_CYCLES > 0) begin
            state    <= WAIT;
            wait_cnt <= 3'd1;
          end else begin
            state <= DONE;
            if (req_load)
              rd_data_q <= load_extend(bus.sram_dout, req_lane, req_size, req_uns);
          end
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state    <= DONE;
            wait_cnt <= 3'd0;
            if (req_load)
              rd_data_q <= load_extend(bus.sram_dout, req_lane, req_size, req_uns);
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        default: begin
          // DONE ignores any pending request; it is re-sampled in IDLE
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_data_ctrl.md
MEM_DATA_CTRL -- requirements
Module: mem_data_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, SRAM read/write wait states after the access cycle; legal range 0..7.
REQ-002 clk  input  1  Single system clock; all state changes on posedge clk.
REQ-003 rst  input  1  Synchronous, active-high reset, sampled on posedge clk.
REQ-004 MEM_in  input  2  Bit1 MemRead, bit0 MemWrite, from EX/MEM register; both high is treated as MemRead.
REQ-005 Address_in  input  `DATA_MEM_ADDR_BITS (13)  Byte address of the access.
REQ-006 Size_in  input  2  00 byte, 01 half, 10 word; 11 is treated as word.
REQ-007 Unsigned_in  input  1  Zero-extend loads when 1, sign-extend when 0.
REQ-008 Write_data_in  input  `INTERNAL_BITS (32)  Store data, right-aligned.
REQ-009 Read_data_out  output  32  Extended load result, feeds MEM/WB Read_data_in.
REQ-010 stall  output  1  Freeze IF/ID/EX/MEM pipeline registers while high.
REQ-011 misalign  output  1  One-cycle pulse flagging a rejected misaligned access.
REQ-012 sram_cs  output  1  SRAM chip select.
REQ-013 sram_we  output  4  SRAM byte write enables; bit n writes byte lane n.
REQ-014 sram_addr  output  11  SRAM word address (Address_in[12:2]).
REQ-015 sram_din  output  32  SRAM write data.
REQ-016 sram_dout  input  32  SRAM read data, valid WAIT_CYCLES cycles after the cycle in which sram_cs is asserted.

Function
REQ-017 The FSM SHALL have states IDLE, ACCESS, WAIT and DONE.
REQ-018 IDLE: a request (MemRead or MemWrite high) that is aligned SHALL drive stall=1 combinationally and move the FSM to ACCESS.
REQ-019 Misaligned means half with addr[0]=1, or word with addr[1:0]!=00; in IDLE such a request SHALL assert misalign for that cycle, keep stall=0, issue no SRAM access, and keep the FSM in IDLE.
REQ-020 On entry to ACCESS, registered sram_cs=1, sram_addr, sram_we and sram_din SHALL be presented for exactly one cycle; sram_we SHALL be 0000 for loads.
REQ-021 Store lanes: byte -> we=0001<<addr[1:0] with data replicated in all 4 lanes; half -> we=0011<<addr[1:0] with the halfword replicated in both halves; word -> we=1111.
REQ-022 ACCESS SHALL go to WAIT when WAIT_CYCLES>0, else directly to DONE; WAIT SHALL count WAIT_CYCLES cycles in total, then go to DONE.
REQ-023 For loads, sram_dout SHALL be captured on the edge entering DONE, and the lane selected by addr[1:0] SHALL be extended per Size_in/Unsigned_in into Read_data_out.
REQ-024 Request fields SHALL be latched on leaving IDLE; input changes during ACCESS/WAIT/DONE SHALL be ignored.
REQ-025 stall SHALL be 1 in ACCESS and WAIT and 0 in DONE; DONE SHALL return to IDLE unconditionally after one cycle.
REQ-026 Total stall per aligned access = 2+WAIT_CYCLES cycles; Read_data_out SHALL be valid in the DONE cycle and held until the next load completes.
REQ-027 Stores SHALL leave Read_data_out unchanged.
REQ-028 A request present in the same cycle as DONE SHALL not start an access; it is sampled again in the following IDLE cycle.

Reset
REQ-029 rst high at a clock edge SHALL force IDLE, the wait counter to 0, and Read_data_out, sram_we and sram_din to 0, and sram_cs, stall and misalign to 0, overriding any state.
REQ-030 Reset during ACCESS or WAIT SHALL abort the access; no Read_data_out update, and the SRAM deasserts on the reset edge.
REQ-031 After reset release, the first request SHALL be accepted in the first IDLE cycle.

Verification
REQ-032 WAIT_CYCLES=1, lw addr 0x0010, SRAM word 0xDEADBEEF -> sram_cs for 1 cycle, sram_addr=0x004, stall high 3 cycles, Read_data_out=0xDEADBEEF in DONE.
REQ-033 lb addr 0x0013 (signed), SRAM word 0x80FF_1234 -> Read_data_out=0xFFFFFF80; lbu same -> 0x00000080.
REQ-034 sh addr 0x0006, data 0x0000ABCD -> sram_we=1100, sram_din=0xABCDABCD, Read_data_out unchanged.
REQ-035 lw addr 0x0002 -> misalign=1 for 1 cycle, stall=0, sram_cs never asserted.
REQ-036 WAIT_CYCLES=3, lw started, rst asserted in second WAIT cycle -> next edge: IDLE, all outputs 0; following lw completes normally.
REQ-037 WAIT_CYCLES=0, sw addr 0x1FFC -> sram_addr=0x7FF, we=1111, stall high exactly 2 cycles.
